// File: rtl/ysyx_mc_core.sv
// Multi-cycle RV32I/E core: FETCH -> WAIT -> EXEC per instruction, valid/ready fetch port,
// retire trace and sticky halt/trap status for the simulation environment.
module ysyx_mc_core #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000,
   parameter int          NR_REG   = 32,
   parameter int          XLEN     = 32
) (
   input  logic            clk,
   input  logic            rst,
   output logic            ifu_req_valid,
   output logic [XLEN-1:0] ifu_req_addr,
   input  logic            ifu_req_ready,
   input  logic            ifu_rsp_valid,
   input  logic [31:0]     ifu_rsp_inst,
   output logic            retire,
   output logic [XLEN-1:0] retire_pc,
   output logic            halt,
   output logic            trap,
   output logic [XLEN-1:0] halt_code,
   input  logic [4:0]      dbg_raddr,
   output logic [XLEN-1:0] dbg_rdata
);

   localparam int         IW = $clog2(NR_REG);
   localparam logic [5:0] NR = 6'(NR_REG);

   typedef enum logic [1:0] {S_FETCH, S_WAIT, S_EXEC, S_HALT} state_t;

   state_t          state_q;
   logic [XLEN-1:0] pc_q;
   logic [31:0]     inst_q;
   logic [XLEN-1:0] regs_q [NR_REG];
   logic            retire_q;
   logic [XLEN-1:0] retire_pc_q;
   logic            halt_q;
   logic            trap_q;
   logic [XLEN-1:0] halt_code_q;

   logic [6:0]      opcode;
   logic [4:0]      rd, rs1;
   logic [2:0]      funct3;
   logic [XLEN-1:0] imm_i, imm_u, imm_j;
   logic [XLEN-1:0] rs1_val, x10_val;
   logic [XLEN-1:0] jal_t, jalr_t;
   logic            rd_bad, rs1_bad;
   logic            is_addi, is_lui, is_auipc, is_jal, is_jalr, is_ebreak;
   logic            exc_trap, wen;
   logic [XLEN-1:0] wdata, pc_d;

   assign opcode = inst_q[6:0];
   assign rd     = inst_q[11:7];
   assign funct3 = inst_q[14:12];
   assign rs1    = inst_q[19:15];
   assign imm_i  = {{20{inst_q[31]}}, inst_q[31:20]};
   assign imm_u  = {inst_q[31:12], 12'b0};
   assign imm_j  = {{11{inst_q[31]}}, inst_q[31], inst_q[19:12], inst_q[20], inst_q[30:21], 1'b0};

   assign rd_bad  = {1'b0, rd} >= NR;
   assign rs1_bad = {1'b0, rs1} >= NR;

   // Out-of-range indices read as zero so the debug port never aliases a lower register.
   assign rs1_val   = (rs1 == 5'd0 || rs1_bad) ? '0 : regs_q[rs1[IW-1:0]];
   assign x10_val   = regs_q[4'd10];
   assign dbg_rdata = (dbg_raddr == 5'd0 || {1'b0, dbg_raddr} >= NR) ? '0
                                                                     : regs_q[dbg_raddr[IW-1:0]];

   assign is_addi   = (opcode == 7'h13) && (funct3 == 3'b000);
   assign is_lui    = (opcode == 7'h37);
   assign is_auipc  = (opcode == 7'h17);
   assign is_jal    = (opcode == 7'h6f);
   assign is_jalr   = (opcode == 7'h67) && (funct3 == 3'b000);
   assign is_ebreak = (inst_q == 32'h0010_0073);

   assign jal_t  = pc_q + imm_j;
   assign jalr_t = (rs1_val + imm_i) & ~32'h1;

   always_comb begin
      exc_trap = 1'b0;
      wen      = 1'b0;
      wdata    = '0;
      pc_d     = pc_q + 32'd4;
      if (is_addi) begin
         wen      = 1'b1;
         wdata    = rs1_val + imm_i;
         exc_trap = rd_bad || rs1_bad;
      end else if (is_lui) begin
         wen      = 1'b1;
         wdata    = imm_u;
         exc_trap = rd_bad;
      end else if (is_auipc) begin
         wen      = 1'b1;
         wdata    = pc_q + imm_u;
         exc_trap = rd_bad;
      end else if (is_jal) begin
         wen      = 1'b1;
         wdata    = pc_q + 32'd4;
         pc_d     = jal_t;
         exc_trap = rd_bad || jal_t[1];
      end else if (is_jalr) begin
         wen      = 1'b1;
         wdata    = pc_q + 32'd4;
         pc_d     = jalr_t;
         exc_trap = rd_bad || rs1_bad || jalr_t[1];
      end else if (!is_ebreak) begin
         exc_trap = 1'b1;
      end
      wen = wen && !exc_trap && (rd != 5'd0);
   end

   // Held low while reset is asserted even though the state register already reads FETCH.
   assign ifu_req_valid = (state_q == S_FETCH) && rst;
   assign ifu_req_addr  = pc_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NR_REG; i++) regs_q[i] <= '0;
      end else if (state_q == S_EXEC && wen) begin
         regs_q[rd[IW-1:0]] <= wdata;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_FETCH;
         pc_q        <= RESET_PC;
         inst_q      <= '0;
         retire_q    <= 1'b0;
         retire_pc_q <= '0;
         halt_q      <= 1'b0;
         trap_q      <= 1'b0;
         halt_code_q <= '0;
      end else begin
         retire_q <= 1'b0;
         case (state_q)
            S_FETCH: if (ifu_req_ready) state_q <= S_WAIT;
            S_WAIT: begin
               if (ifu_rsp_valid) begin
                  inst_q  <= ifu_rsp_inst;
                  state_q <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (exc_trap) begin
                  halt_q      <= 1'b1;
                  trap_q      <= 1'b1;
                  halt_code_q <= x10_val;
                  state_q     <= S_HALT;
               end else begin
                  retire_q    <= 1'b1;
                  retire_pc_q <= pc_q;
                  if (is_ebreak) begin
                     halt_q      <= 1'b1;
                     halt_code_q <= x10_val;
                     state_q     <= S_HALT;
                  end else begin
                     pc_q    <= pc_d;
                     state_q <= S_FETCH;
                  end
               end
            end
            default: state_q <= S_HALT;
         endcase
      end
   end

   assign retire    = retire_q;
   assign retire_pc = retire_pc_q;
   assign halt      = halt_q;
   assign trap      = trap_q;
   assign halt_code = halt_code_q;

endmodule

// File: doc/ysyx_mc_core.md
Name: ysyx_mc_core

Overview:
Parametrised multi-cycle RV32 core top, successor to the single-cycle core top. Fetches instructions through a valid/ready request and response interface instead of a combinational instruction input. Executes the RV32I/E integer subset ADDI, LUI, AUIPC, JAL, JALR and EBREAK. Provides a halt/trap status and retire trace for the simulation environment.

Parameters:
RESET_PC, 32'h8000_0000, PC value loaded on reset.
NR_REG, 32, number of architectural registers; 16 (RV32E) or 32 (RV32I).
XLEN, 32, datapath width; only 32 is legal.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-low reset.
ifu_req_valid  out  1  fetch request valid.
ifu_req_addr  out  XLEN  fetch address (= pc).
ifu_req_ready  in  1  memory accepts request.
ifu_rsp_valid  in  1  instruction word valid.
ifu_rsp_inst  in  32  instruction word.
retire  out  1  one-cycle pulse per retired instruction.
retire_pc  out  XLEN  pc of the retired instruction.
halt  out  1  core stopped (sticky).
trap  out  1  halt was caused by an illegal instruction or misaligned target.
halt_code  out  XLEN  value of x10 at halt.
dbg_raddr  in  5  debug register index.
dbg_rdata  out  XLEN  combinational register read; 0 for x0 or index >= NR_REG.

Behaviour:
- Reset (rst=0, async):
  - pc=RESET_PC; all registers 0; state=FETCH.
  - ifu_req_valid=0 during reset; retire=0, halt=0, trap=0, halt_code=0, retire_pc=0.
- States: FETCH, WAIT, EXEC, HALT.
- FETCH:
  - Drive ifu_req_valid=1, ifu_req_addr=pc.
  - Hold valid and address stable until ifu_req_ready=1 is sampled, then go to WAIT.
  - ifu_rsp_valid in FETCH is ignored.
- WAIT:
  - Response is always accepted (no rsp ready signal); ifu_req_valid=0.
  - On ifu_rsp_valid=1, latch ifu_rsp_inst into inst register, then go to EXEC.
  - Same-cycle request accept + response is not possible: a response is earliest one cycle after acceptance.
- EXEC (exactly one cycle):
  - Decode inst.
  - Write rd if rd!=0.
  - Update pc; pulse retire=1 with retire_pc=old pc; go to FETCH.
- Minimum instruction latency: 3 cycles with ready and response both immediate.
- Semantics (all 32-bit, wrap-around modulo 2^32, no overflow detection):
  - ADDI: rd=rs1+sext(imm12).
  - LUI: rd={imm20,12'b0}.
  - AUIPC: rd=pc+{imm20,12'b0}.
  - JAL: rd=pc+4; pc=pc+sext(imm21).
  - JALR: t=(rs1+sext(imm12))&~1; rd=pc+4; pc=t. rs1 is read before rd is written, so rd==rs1 works.
  - All others: pc=pc+4.
- x0 reads 0; writes to x0 are discarded.
- EBREAK (32'h0010_0073):
  - halt=1, trap=0, halt_code=x10; retire pulses; go to HALT.
- Trap conditions (go to HALT with halt=1, trap=1, halt_code=x10; no register write, no pc update, retire not pulsed):
  - Any other encoding.
  - rd, rs1 or rs2 field >= NR_REG in a used field.
  - JAL/JALR target with bit1 set (misaligned).
- HALT: terminal; ifu_req_valid=0; pc and registers frozen; dbg_rdata stays readable. Exit only via reset.
- Reset asserted mid-transaction (FETCH/WAIT):
  - Pending request abandoned; state=FETCH after release.
  - A late ifu_rsp_valid arriving while in FETCH is ignored.

Test Plan:
- Reset, ready=1, rsp one cycle after accept: fetch addr 0x8000_0000. Inst 0x00500093 (addi x1,x0,5) → retire pc 0x8000_0000; dbg x1=5; next req addr 0x8000_0004; retire spacing 3 cycles.
- Backpressure: ifu_req_ready=0 for 4 cycles → ifu_req_valid held 1 and ifu_req_addr unchanged; no retire until accept + response.
- Writeback and wrap-around:
  - 0x12345137 (lui x2,0x12345) → x2=0x12345000.
  - 0x00100013 (addi x0,x0,1) → x0 stays 0.
  - addi x3,x0,-1 then addi x3,x3,1 → x3=0.
- Jump: 0x008000ef (jal x1,8) at 0x8000_0000 → x1=0x8000_0004, next fetch 0x8000_0008. JALR with rs1 odd result → low bit cleared. JALR target ending 0x2 → halt=1, trap=1.
- Halt: x10=0x2A, then 0x00100073 → halt=1, trap=0, halt_code=0x2A, no further requests. With NR_REG=16, addi x20,x0,1 → trap=1.
- Reset pulse during WAIT, then response arrives → response ignored; first request after release at RESET_PC; all registers 0.
